// File: rtl/apb_bfm_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// apb_bfm_pkg : shared types and helpers for the APB3 slave memory BFM
// Rev 1.0
// ---------------------------------------------------------------------------
package apb_bfm_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  localparam int unsigned WAIT_CNT_W = 4;

  // Any set bit above the word index (within the low 24 address bits) is out of range.
  function automatic logic range_err(input logic [23:0] addr, input int unsigned awidth);
    return (addr >> (awidth + 32'd2)) != 24'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_bfm_ram.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// apb_bfm_ram : DEPTH x 32 word RAM, synchronous write, asynchronous read
// Rev 1.0
// ---------------------------------------------------------------------------
module apb_bfm_ram #(
  parameter int unsigned AWIDTH = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int unsigned DEPTH = 2 ** AWIDTH;

  logic [31:0] mem [DEPTH] = '{default: 32'h0};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule
`default_nettype wire

// File: rtl/apb_slave_mem_bfm.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// apb_slave_mem_bfm : APB3 slave memory with wait states, read-only window,
//                     out-of-range PSLVERR and a sticky protocol checker
// Rev 1.0
// ---------------------------------------------------------------------------
module apb_slave_mem_bfm
  import apb_bfm_pkg::*;
#(
  parameter int unsigned AWIDTH   = 8,
  parameter int unsigned WAITS    = 0,
  parameter int unsigned RO_WORDS = 0,
  parameter int unsigned TPD      = 1
) (
  input  logic        HCLK,
  input  logic        HRESETN,
  input  logic        PSEL,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        PROTERR
);

  localparam logic [WAIT_CNT_W-1:0] WAITS_CNT = WAIT_CNT_W'(WAITS);

  if ((WAITS > (2 ** WAIT_CNT_W) - 1) || (AWIDTH == 0) || (AWIDTH > 22) || (TPD > 1000))
  begin : g_param_check
    $error("apb_slave_mem_bfm: parameter out of range");
  end

  apb_state_e            state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic                  proterr_q, proterr_d;

  logic [AWIDTH-1:0]     setup_idx;
  logic                  setup_err;
  logic                  mem_we;
  logic [31:0]           mem_rdata;
  logic                  ready;

  assign setup_idx = PADDR[AWIDTH+1:2];
  // Read-only test done in 33 bits so RO_WORDS=0 never degenerates into a constant compare.
  assign setup_err = range_err(PADDR[23:0], AWIDTH)
                   | (PWRITE & ((33'(setup_idx) + 33'd1) <= 33'(RO_WORDS)));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    proterr_d = proterr_q;
    mem_we    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          addr_d  = PADDR;
          wr_d    = PWRITE;
          wdata_d = PWDATA;
          err_d   = setup_err;
          cnt_d   = WAITS_CNT;
          state_d = ST_ACCESS;
        end else if (PSEL && PENABLE) begin
          proterr_d = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (!PSEL || !PENABLE) begin
          proterr_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
          // Master must hold the transfer stable; the access still completes on latched values.
          if ((PADDR != addr_q) || (PWRITE != wr_q) || (PWDATA != wdata_q)) begin
            proterr_d = 1'b1;
          end
        end else begin
          mem_we  = wr_q & ~err_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      proterr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      proterr_q <= proterr_d;
    end
  end

  apb_bfm_ram #(
    .AWIDTH (AWIDTH)
  ) u_ram (
    .clk   (HCLK),
    .we    (mem_we),
    .addr  (addr_q[AWIDTH+1:2]),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  assign ready   = (state_q == ST_ACCESS) & PSEL & PENABLE & (cnt_q == '0);
  assign PREADY  = ready;
  assign PSLVERR = ready & err_q;
  assign PRDATA  = (ready & ~wr_q & ~err_q) ? mem_rdata : 32'h0;
  assign PROTERR = proterr_q;

endmodule
`default_nettype wire
